mlp_layer_engine: RTL and testbench

Sequential multi-layer perceptron compute engine that sits directly downstream of the per-layer weight memory. It drives `layer_addr`, consumes the combinational `weights_out` bundle for the addressed layer (N neurons × bias plus N weights), and evaluates all M layers in turn on one captured N-element input vector. It returns the final activation vector through a valid/ready handshake. N neuron MACs run in parallel, each stepping serially through bias and inputs, with a ReLU-and-saturate writeback per layer.

---
 rtl/mlp_layer_engine.sv | 151 +++++++++++++++
 tb/tb_mlp_layer_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_engine.sv
// Sequential M-layer, N-neuron perceptron engine. It runs N parallel MACs, each stepping
// serially over bias and inputs, then does a ReLU/saturate writeback at the end of each layer.
//
// state | meaning
// IDLE  | waiting for an input vector, in_ready high
// MAC   | k=0 loads bias<<FRAC, k=1..N accumulates weight*activation
// ACT   | shift, saturate and ReLU all accumulators into act; advance layer or finish
// DONE  | y_out held with out_valid high until out_ready
module mlp_layer_engine #(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N-1:0][WIDTH-1:0]       x_in,
  output logic [$clog2(M)-1:0]          layer_addr,
  input  logic [N-1:0][N:0][WIDTH-1:0]  weights_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N-1:0][WIDTH-1:0]       y_out,
  output logic                          busy
);
  localparam int ACC_W = 2 * WIDTH + $clog2(N + 1);
  localparam int KW    = $clog2(N + 1);
  localparam int AW    = (N > 1) ? $clog2(N) : 1;
  localparam int LW    = $clog2(M);

  typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

  state_t                     state_q, state_d;
  logic [N-1:0][WIDTH-1:0]    act_q, act_d;
  logic [N-1:0][ACC_W-1:0]    acc_q, acc_d;
  logic [KW-1:0]              k_q, k_d;
  logic [LW-1:0]              layer_q, layer_d;
  logic [N-1:0][WIDTH-1:0]    y_q, y_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic                       busy_q, busy_d;

  logic [AW-1:0]              km1;
  logic [N-1:0][2*WIDTH-1:0]  prod;
  logic [N-1:0][ACC_W-1:0]    sh;
  logic [N-1:0][WIDTH-1:0]    act_new;

  // km1 wraps when k_q is 0; the product is unused in that step.
  always_comb begin
    km1 = AW'(k_q - 1'b1);
    for (int j = 0; j < N; j++) begin
      prod[j] = $signed(weights_in[j][k_q]) * $signed(act_q[km1]);
      sh[j]   = $signed(acc_q[j]) >>> FRAC;
      if (sh[j][ACC_W-1])
        act_new[j] = '0;
      else if (|sh[j][ACC_W-2:WIDTH-1])
        act_new[j] = {1'b0, {(WIDTH-1){1'b1}}};
      else
        act_new[j] = sh[j][WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    acc_d       = acc_q;
    k_d         = k_q;
    layer_d     = layer_q;
    y_d         = y_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          act_d      = x_in;
          layer_d    = '0;
          k_d        = '0;
          state_d    = MAC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      MAC: begin
        for (int j = 0; j < N; j++) begin
          if (k_q == '0)
            acc_d[j] = {{(ACC_W-WIDTH){weights_in[j][0][WIDTH-1]}}, weights_in[j][0]} << FRAC;
          else
            acc_d[j] = acc_q[j] + {{(ACC_W-2*WIDTH){prod[j][2*WIDTH-1]}}, prod[j]};
        end
        if (k_q == KW'(N))
          state_d = ACT;
        else
          k_d = k_q + 1'b1;
      end
      ACT: begin
        act_d = act_new;
        if (layer_q == LW'(M - 1)) begin
          y_d         = act_new;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          layer_d = layer_q + 1'b1;
          k_d     = '0;
          state_d = MAC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      act_q       <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      layer_q     <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      layer_q     <= layer_d;
      y_q         <= y_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign layer_addr = layer_q;
  assign y_out      = y_q;

endmodule

// File: tb/tb_mlp_layer_engine.sv
// Bench for mlp_layer_engine: directed and randomized vectors checked against an
// arithmetic reference of the layer equations, plus latency, backpressure and reset cases.
module tb_mlp_layer_engine;
  localparam int N = 4, M = 4, WIDTH = 16, FRAC = 8;
  localparam int LAT = M * (N + 2);
  typedef logic [N-1:0][WIDTH-1:0] vec_t;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, busy;
  vec_t x_in, y_out;
  logic [$clog2(M)-1:0] layer_addr;
  logic [N-1:0][N:0][WIDTH-1:0] weights_in;
  logic [WIDTH-1:0] wmem [M][N][N+1];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Combinational weight memory addressed by the engine.
  always_comb begin
    for (int j = 0; j < N; j++)
      for (int k = 0; k <= N; k++)
        weights_in[j][k] = wmem[layer_addr][j][k];
  end

  mlp_layer_engine #(.N(N), .M(M), .WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .layer_addr(layer_addr), .weights_in(weights_in), .out_valid(out_valid),
    .out_ready(out_ready), .y_out(y_out), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic vec_t model(input vec_t x);
    longint a [N];
    longint na [N];
    longint acc, t;
    vec_t y;
    for (int n = 0; n < N; n++) a[n] = longint'($signed(x[n]));
    for (int l = 0; l < M; l++) begin
      for (int j = 0; j < N; j++) begin
        acc = longint'($signed(wmem[l][j][0])) * (longint'(1) << FRAC);
        for (int k = 1; k <= N; k++)
          acc += longint'($signed(wmem[l][j][k])) * a[k-1];
        t = acc >>> FRAC;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        if (t < 0) t = 0;
        na[j] = t;
      end
      a = na;
    end
    for (int n = 0; n < N; n++) y[n] = WIDTH'(a[n]);
    return y;
  endfunction

  function automatic vec_t rand_vec(input int span);
    vec_t v;
    for (int n = 0; n < N; n++) v[n] = WIDTH'($urandom_range(0, 2 * span) - span);
    return v;
  endfunction

  task automatic set_identity();
    for (int l = 0; l < M; l++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k <= N; k++)
          wmem[l][j][k] = (k == j + 1) ? 16'd256 : 16'd0;
  endtask

  task automatic set_random(input int span);
    for (int l = 0; l < M; l++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k <= N; k++)
          wmem[l][j][k] = WIDTH'($urandom_range(0, 2 * span) - span);
  endtask

  task automatic start(input vec_t x);
    x_in = x;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit chk_addr, output int lat);
    int exp_l;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (chk_addr) begin
        exp_l = lat / (N + 2);
        if (exp_l > M - 1) exp_l = M - 1;
        check("layer_addr", layer_addr, exp_l);
      end
    end
    if (!out_valid) check("out_timeout", 0, 1);
  endtask

  task automatic run(input vec_t x, input bit chk_addr);
    int lat;
    start(x);
    wait_out(chk_addr, lat);
    check("latency", lat, LAT);
    check("y_out", y_out, model(x));
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    vec_t x, e, other;
    int lat, got, cyc;
    bit prev_rdy, seen;
    vec_t q[$];
    int acc_cyc[$];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_in = '0;
    set_identity();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_layer_addr", layer_addr, 0);
    check("rst_y_out", y_out, 0);

    // Identity layers pass the input through unchanged.
    x = {16'd1024, 16'd768, 16'd512, 16'd256};
    run(x, 1'b1);
    check("identity_y", y_out, x);

    // Negative neuron clamps to 0, then a bias of 0.5 re-enters it.
    set_identity();
    wmem[0][0][0] = 16'hFE00;
    wmem[1][0][0] = 16'd128;
    x = {16'd256, 16'd256, 16'd256, 16'd256};
    run(x, 1'b0);
    e = {16'd256, 16'd256, 16'd256, 16'd128};
    check("bias_relu_y", y_out, e);

    set_identity();
    wmem[0][0][1] = 16'h7FFF;
    x = {16'd5, 16'd6, 16'd7, 16'h7FFF};
    run(x, 1'b0);
    check("saturate_y0", y_out[0], 16'h7FFF);

    set_identity();
    wmem[0][0][1] = 16'd383;
    wmem[0][1][2] = 16'hFE81;
    x = {16'd9, 16'd9, 16'd1, 16'd1};
    run(x, 1'b0);
    check("truncate_y0", y_out[0], 16'd1);
    check("truncate_neg_y1", y_out[1], 16'd0);

    for (int i = 0; i < 8; i++) begin
      set_random((i < 4) ? 300 : 2000);
      run(rand_vec((i % 2 == 0) ? 2000 : 32767), 1'b0);
    end

    // Backpressure: result held while out_ready is low, new inputs ignored.
    set_random(300);
    x = rand_vec(2000);
    e = model(x);
    out_ready = 1'b0;
    start(x);
    wait_out(1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      other = rand_vec(2000);
      x_in = other;
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_y_out", y_out, e);
      check("bp_in_ready", in_ready, 0);
      check("bp_layer_addr", layer_addr, M - 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    check("bp_idle_busy", busy, 0);
    check("bp_y_retained", y_out, e);

    // Reset while layer 1 is accumulating.
    set_random(300);
    start(rand_vec(2000));
    repeat (8) @(posedge clk);
    #1;
    check("mid_layer_addr", layer_addr, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_layer_addr", layer_addr, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_valid", seen, 0);
    run(rand_vec(2000), 1'b0);

    // Back-to-back: in_valid held, out_ready tied high.
    set_random(300);
    out_ready = 1'b1;
    x_in = rand_vec(2000);
    in_valid = 1'b1;
    prev_rdy = in_ready;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_rdy && in_valid) begin
        q.push_back(x_in);
        acc_cyc.push_back(cyc);
        x_in = rand_vec(2000);
      end
      if (out_valid) begin
        got++;
        if (q.size() > 0) check("b2b_y_out", y_out, model(q.pop_front()));
        else check("b2b_unexpected_out", 1, 0);
      end
      prev_rdy = in_ready;
    end
    in_valid = 1'b0;
    check("b2b_results", got, 3);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b2b_interval", acc_cyc[i] - acc_cyc[i-1], LAT + 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
